// File: rtl/run_control.sv
// ============================================================================
// run_control : debounced run/pause and clear keys driving an IDLE/RUN/PAUSE
//               controller for a downstream running-circle stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module run_control #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       key_run_ni,
    input  logic       key_clr_ni,
    output logic       en_o,
    output logic       restart_o,
    output logic [1:0] state_o
);

    localparam int            CW        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    logic [1:0] w_key_raw;
    logic [1:0] w_press;
    state_t     r_state;
    logic       r_restart;

    // Bit 0 is the run key, bit 1 the clear key.
    assign w_key_raw = {key_clr_ni, key_run_ni};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_key
            logic [1:0]    r_sync;
            logic          r_level;
            logic          r_level_d;
            logic          r_press;
            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_sync    <= 2'b11;
                    r_level   <= 1'b1;
                    r_level_d <= 1'b1;
                    r_cnt     <= '0;
                    r_press   <= 1'b0;
                end else begin
                    r_sync    <= {r_sync[0], w_key_raw[g]};
                    r_level_d <= r_level;
                    r_press   <= r_level_d & ~r_level;
                    if (r_sync[1] == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == C_CNT_MAX) begin
                        r_level <= r_sync[1];
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_press[g] = r_press;
        end
    endgenerate

    // Clear wins over run; restart only fires when actually leaving RUN/PAUSE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_restart <= 1'b0;
        end else begin
            r_restart <= 1'b0;
            if (w_press[1]) begin
                if (r_state != S_IDLE) begin
                    r_restart <= 1'b1;
                end
                r_state <= S_IDLE;
            end else if (w_press[0]) begin
                case (r_state)
                    S_RUN:   r_state <= S_PAUSE;
                    default: r_state <= S_RUN;
                endcase
            end
        end
    end

    assign en_o      = (r_state == S_RUN);
    assign state_o   = r_state;
    assign restart_o = r_restart;

endmodule

`default_nettype wire

// File: tb/tb_run_control.sv
// ============================================================================
// tb_run_control : window-based reference model of key debounce and the
//                  run/pause/clear controller, directed cases plus random keys.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_run_control;

    localparam int N = 4;

    logic       clk_i      = 1'b0;
    logic       rst_ni     = 1'b0;
    logic       key_run_ni = 1'b1;
    logic       key_clr_ni = 1'b1;
    logic       en_o;
    logic       restart_o;
    logic [1:0] state_o;

    run_control #(.DEBOUNCE_CYCLES(N)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .key_run_ni (key_run_ni),
        .key_clr_ni (key_clr_ni),
        .en_o       (en_o),
        .restart_o  (restart_o),
        .state_o    (state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int restart_seen  = 0;
    int state_changes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw key samples per edge; the level flips when the N
    // samples seen by the debouncer (2..N+1 edges old) all disagree with it.
    bit [N+1:0] hist [2];
    bit         lvl  [2];
    bit [1:0]   fell [2];
    int         m_state;
    bit         m_restart;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            hist[k] = '1;
            lvl[k]  = 1'b1;
            fell[k] = 2'b00;
        end
        m_state   = 0;
        m_restart = 1'b0;
    endfunction

    function automatic void model_step(input bit raw_run, input bit raw_clr);
        bit press [2];
        bit raw   [2];
        bit all_diff;
        raw[0] = raw_run;
        raw[1] = raw_clr;
        for (int k = 0; k < 2; k++) begin
            press[k]   = fell[k][1];
            fell[k][1] = fell[k][0];
            fell[k][0] = 1'b0;
            hist[k]    = {hist[k][N:0], raw[k]};
            all_diff   = 1'b1;
            for (int j = 2; j <= N + 1; j++)
                if (hist[k][j] == lvl[k]) all_diff = 1'b0;
            if (all_diff) begin
                if (lvl[k]) fell[k][0] = 1'b1;
                lvl[k] = ~lvl[k];
            end
        end
        m_restart = 1'b0;
        if (press[1]) begin
            if (m_state != 0) m_restart = 1'b1;
            m_state = 0;
        end else if (press[0]) begin
            m_state = (m_state == 1) ? 2 : 1;
        end
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) model_reset();
            else         model_step(key_run_ni, key_clr_ni);
        end
    end

    // Every-cycle comparison against the model, plus event counters.
    initial begin
        logic [1:0] prev_state;
        prev_state = 2'b00;
        forever begin
            @(negedge clk_i);
            check("state", 32'(state_o), 32'(m_state));
            check("en", 32'(en_o), 32'(m_state == 1));
            check("restart", 32'(restart_o), 32'(m_restart));
            if (restart_o === 1'b1) restart_seen++;
            if (state_o !== prev_state) state_changes++;
            prev_state = state_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic press_run();
        key_run_ni = 1'b0;
        tick(N + 5);
        key_run_ni = 1'b1;
        tick(N + 5);
    endtask

    int rs0;
    int sc0;

    initial begin
        tick(3);
        check("reset_state", 32'(state_o), 0);
        check("reset_en", 32'(en_o), 0);
        check("reset_restart", 32'(restart_o), 0);
        rst_ni = 1'b1;

        // Press sampled on edge 10 after release -> RUN on edge 17.
        tick(9);
        key_run_ni = 1'b0;
        tick(7);
        check("run_edge16_state", 32'(state_o), 0);
        tick(1);
        check("run_edge17_state", 32'(state_o), 1);
        check("run_edge17_en", 32'(en_o), 1);
        key_run_ni = 1'b1;
        tick(N + 5);
        press_run();
        check("pause_state", 32'(state_o), 2);
        check("pause_en", 32'(en_o), 0);

        // Long hold: a single transition PAUSE -> RUN.
        sc0 = state_changes;
        key_run_ni = 1'b0;
        tick(100);
        key_run_ni = 1'b1;
        tick(N + 5);
        check("hold_changes", 32'(state_changes - sc0), 1);
        check("hold_state", 32'(state_o), 1);

        // Clear from RUN.
        rs0 = restart_seen;
        key_clr_ni = 1'b0;
        tick(N + 5);
        key_clr_ni = 1'b1;
        tick(N + 5);
        check("clr_state", 32'(state_o), 0);
        check("clr_en", 32'(en_o), 0);
        check("clr_restart_count", 32'(restart_seen - rs0), 1);

        // Short excursions must be ignored.
        sc0 = state_changes;
        repeat (5) begin
            key_run_ni = 1'b0; tick(2);
            key_run_ni = 1'b1; tick(1);
            key_run_ni = 1'b0; tick(1);
            key_run_ni = 1'b1; tick(3);
        end
        tick(N + 5);
        check("glitch_changes", 32'(state_changes - sc0), 0);
        check("glitch_state", 32'(state_o), 0);

        // Simultaneous presses from PAUSE, then from IDLE.
        press_run();
        press_run();
        check("pre_both_state", 32'(state_o), 2);
        rs0 = restart_seen;
        key_run_ni = 1'b0; key_clr_ni = 1'b0;
        tick(N + 5);
        key_run_ni = 1'b1; key_clr_ni = 1'b1;
        tick(N + 5);
        check("both_pause_state", 32'(state_o), 0);
        check("both_pause_restart", 32'(restart_seen - rs0), 1);
        rs0 = restart_seen;
        key_run_ni = 1'b0; key_clr_ni = 1'b0;
        tick(N + 5);
        key_run_ni = 1'b1; key_clr_ni = 1'b1;
        tick(N + 5);
        check("both_idle_state", 32'(state_o), 0);
        check("both_idle_restart", 32'(restart_seen - rs0), 0);

        // Reset asserted mid-cycle while in RUN.
        press_run();
        rs0 = restart_seen;
        #2 rst_ni = 1'b0;
        tick(3);
        check("rst_run_state", 32'(state_o), 0);
        rst_ni = 1'b1;
        tick(20);
        check("rst_after_state", 32'(state_o), 0);
        check("rst_after_en", 32'(en_o), 0);
        check("rst_restart_count", 32'(restart_seen - rs0), 0);

        // Key held across reset counts as a fresh press.
        key_run_ni = 1'b0;
        tick(2);
        rst_ni = 1'b0;
        tick(2);
        rst_ni = 1'b1;
        tick(N + 6);
        check("held_through_reset_state", 32'(state_o), 1);
        key_run_ni = 1'b1;
        tick(N + 5);

        // Random key activity with occasional asynchronous resets.
        for (int it = 0; it < 600; it++) begin
            key_run_ni = ($urandom_range(0, 2) != 0);
            key_clr_ni = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 60) == 0) begin
                #3 rst_ni = 1'b0;
                tick($urandom_range(1, 3));
                rst_ni = 1'b1;
            end
            tick($urandom_range(1, 3 * N));
        end
        key_run_ni = 1'b1;
        key_clr_ni = 1'b1;
        tick(N + 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/run_control.md
RUN_CONTROL -- requirements
Module: run_control

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, the number of consecutive stable cycles needed to accept a key level (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port key_run_ni, input, 1, raw run/pause push-button; asynchronous; low = pressed.
REQ-005 SHALL have port key_clr_ni, input, 1, raw clear push-button; asynchronous; low = pressed.
REQ-006 SHALL have port en_o, output, 1, run enable for the downstream running-circle stage's en_i.
REQ-007 SHALL have port restart_o, output, 1, one-cycle pulse when the block returns to IDLE from RUN or PAUSE.
REQ-008 SHALL have port state_o, output, 2, current state: IDLE=00, RUN=01, PAUSE=10; 11 never driven.

Function
REQ-009 Each key SHALL pass through its own 2-flop synchronizer before any other use.
REQ-010 Each key SHALL have its own debounced level register and debounce counter, ceil(log2(DEBOUNCE_CYCLES)) bits wide.
REQ-011 While the synchronized key equals its debounced level, that key's counter SHALL be cleared to 0.
REQ-012 While the synchronized key differs from its debounced level and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-013 While they differ and the counter equals DEBOUNCE_CYCLES-1, the debounced level SHALL take the synchronized value and the counter SHALL clear to 0.
REQ-014 Any excursion shorter than DEBOUNCE_CYCLES-1 consecutive synchronized cycles SHALL leave the debounced level unchanged, and the counter SHALL restart from 0.
REQ-015 A registered press pulse SHALL assert for exactly one cycle, the cycle after a debounced level goes 1->0; a release (0->1) SHALL generate no pulse.
REQ-016 A held key SHALL generate exactly one press pulse; no auto-repeat.
REQ-017 FSM transitions SHALL occur on the edge on which a press pulse is high:
- IDLE + run press -> RUN
- RUN + run press -> PAUSE
- PAUSE + run press -> RUN
- any state + clr press -> IDLE
REQ-018 A clr press SHALL take priority over a run press in the same cycle.
REQ-019 A clr press in IDLE SHALL leave the state in IDLE and SHALL NOT pulse restart_o.
REQ-020 en_o SHALL be 1 exactly while the state is RUN, decoded from the state register with no extra delay.
REQ-021 restart_o SHALL be registered and SHALL be high for the single cycle after the edge on which the state changes RUN->IDLE or PAUSE->IDLE.
REQ-022 Latency: when key_run_ni is first sampled low at edge k and held, the state SHALL change at edge k+DEBOUNCE_CYCLES+3.
REQ-023 On that same edge (k+DEBOUNCE_CYCLES+3), en_o and state_o SHALL update.
REQ-024 Both keys SHALL be processed independently and concurrently.

Reset
REQ-025 While rst_ni is low, synchronizer flops and debounced levels SHALL be 1 (released).
REQ-026 While rst_ni is low, debounce counters and press pulses SHALL be 0.
REQ-027 While rst_ni is low, state SHALL be IDLE, en_o=0, restart_o=0 and state_o=00.
REQ-028 Reset assertion mid-debounce or in RUN/PAUSE SHALL take effect immediately, with no pulse on restart_o.
REQ-029 After reset, a key still held low SHALL be treated as a new press once debounced.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Run key low at edge 10, held -> en_o=1 and state_o=01 from edge 17; release then re-press -> state_o=10, en_o=0.
REQ-031 Run key low for 2 cycles with glitches, repeated 5 times -> state_o stays 00 and en_o stays 0.
REQ-032 From RUN, clr press -> state_o=00, en_o=0, restart_o high for exactly 1 cycle.
REQ-033 Run and clr pressed on the same edge from PAUSE -> state_o=00 and restart_o pulses once; from IDLE -> stays 00 with no restart_o pulse.
REQ-034 Run key held 100 cycles -> exactly one state change.
REQ-035 rst_ni low in RUN, then high with keys released -> state_o=00, en_o=0, restart_o never asserted.
